// File: rtl/serial_shift_rx_if.sv
// Link and parallel-output bundle for serial_shift_rx.
// The slave modport is the receiver; the master modport is whatever drives the link and consumes the frame.
interface serial_shift_rx_if #(
  parameter int WIDTH = 64
);
  localparam int CNT_W = $clog2(WIDTH + 1) + 1;

  logic             s_clk;
  logic             s_dat;
  logic             s_pen;
  logic             s_clrn;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      frame_cnt;

  modport master (
    output s_clk, s_dat, s_pen, s_clrn,
    input  data_out, data_valid, frame_err, busy, bit_cnt, frame_cnt
  );

  modport slave (
    input  s_clk, s_dat, s_pen, s_clrn,
    output data_out, data_valid, frame_err, busy, bit_cnt, frame_cnt
  );
endinterface

// File: rtl/serial_shift_rx.sv
// Oversampling deserializer for the shift-register display link (MSB-first, bit-count checked).
// Optional good-frame counter is built only when SERIAL_RX_FRAME_CNT_EN is defined.
module serial_shift_rx #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  serial_shift_rx_if.slave link
);
  localparam int CNT_W = $clog2(WIDTH + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  // Per-stage packing is {s_clk, s_dat, s_pen, s_clrn}; idle link has pen and clrn high.
  localparam logic [3:0] LINK_IDLE = 4'b0011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [4*SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]               prev_q, prev_d;
  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         shift_q, shift_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]         data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     frame_err_q, frame_err_d;

  logic clk_s, dat_s, pen_s, clrn_s;
  logic clk_rise, pen_rise, pen_fall;

  always_comb begin
    sync_d = {sync_q[4*(SYNC_STAGES-1)-1:0], link.s_clk, link.s_dat, link.s_pen, link.s_clrn};
    {clk_s, dat_s, pen_s, clrn_s} = sync_q[4*SYNC_STAGES-1 -: 4];
    prev_d   = {clk_s, pen_s};
    clk_rise = clk_s & ~prev_q[1];
    pen_rise = pen_s & ~prev_q[0];
    pen_fall = ~pen_s & prev_q[0];
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (!clrn_s) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pen_fall) begin
            state_d   = SHIFT;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
        SHIFT: begin
          // A bit arriving with the latch edge is still part of this frame.
          if (clk_rise) begin
            shift_d = {shift_q[WIDTH-2:0], dat_s};
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (pen_rise) state_d = COMMIT;
        end
        COMMIT: begin
          if (bit_cnt_q == CNT_FULL) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          shift_d   = '0;
          bit_cnt_d = '0;
          // Catch a new frame starting right behind the latch pulse.
          state_d = pen_fall ? SHIFT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= {SYNC_STAGES{LINK_IDLE}};
      prev_q       <= 2'b01;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef SERIAL_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (data_valid_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Only rst clears the counter; link clears leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign link.frame_cnt = frame_cnt_q;
`else
  assign link.frame_cnt = 16'd0;
`endif

  assign link.data_out   = data_out_q;
  assign link.data_valid = data_valid_q;
  assign link.frame_err  = frame_err_q;
  assign link.busy       = (state_q == SHIFT);
  assign link.bit_cnt    = bit_cnt_q;
endmodule

// File: tb/tb_serial_shift_rx.sv
// Directed bench for serial_shift_rx: a 64-bit receiver and a 16-bit receiver share one link driver.
module tb_serial_shift_rx;
  localparam int HALF = 8;
`ifdef SERIAL_RX_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [63:0] FRAME_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FRAME_B = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] FRAME_C = 64'h8000_0000_0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_clk = 1'b0, drv_dat = 1'b0, drv_pen = 1'b1, drv_clrn = 1'b1;
  logic sel16 = 1'b0;

  int checks = 0;
  int failures = 0;
  int vld64 = 0, err64 = 0, vld16 = 0, err16 = 0;

  always #5 clk = ~clk;

  serial_shift_rx_if #(.WIDTH(64)) lnk64 ();
  serial_shift_rx_if #(.WIDTH(16)) lnk16 ();

  assign lnk64.s_clk  = sel16 ? 1'b0 : drv_clk;
  assign lnk64.s_dat  = sel16 ? 1'b0 : drv_dat;
  assign lnk64.s_pen  = sel16 ? 1'b1 : drv_pen;
  assign lnk64.s_clrn = sel16 ? 1'b1 : drv_clrn;
  assign lnk16.s_clk  = sel16 ? drv_clk  : 1'b0;
  assign lnk16.s_dat  = sel16 ? drv_dat  : 1'b0;
  assign lnk16.s_pen  = sel16 ? drv_pen  : 1'b1;
  assign lnk16.s_clrn = sel16 ? drv_clrn : 1'b1;

  serial_shift_rx #(.WIDTH(64), .SYNC_STAGES(2)) u_rx64 (
    .clk  (clk),
    .rst  (rst),
    .link (lnk64.slave)
  );

  serial_shift_rx #(.WIDTH(16), .SYNC_STAGES(2)) u_rx16 (
    .clk  (clk),
    .rst  (rst),
    .link (lnk16.slave)
  );

  // Strobe cycles are counted so a stretched or repeated pulse shows up as a count error.
  always @(negedge clk) begin
    if (lnk64.data_valid) vld64++;
    if (lnk64.frame_err)  err64++;
    if (lnk16.data_valid) vld16++;
    if (lnk16.frame_err)  err16++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] expCnt(input int n);
    return CNT_EN ? 64'(n) : 64'd0;
  endfunction

  task automatic startFrame();
    drv_pen = 1'b0;
    waitCycles(HALF);
  endtask

  // Shifts bits[nbits-1] first; optionally raises s_pen together with the last s_clk rise.
  task automatic applyStimulus(input logic [127:0] bits, input int nbits, input bit pen_with_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      drv_dat = bits[i];
      waitCycles(HALF);
      drv_clk = 1'b1;
      if (pen_with_last && i == 0) drv_pen = 1'b1;
      waitCycles(HALF);
      drv_clk = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [127:0] bits, input int nbits);
    startFrame();
    applyStimulus(bits, nbits, 1'b0);
    waitCycles(4);
    drv_pen = 1'b1;
    waitCycles(HALF);
  endtask

  initial begin
    int v0, e0;
    $display("[TB] start");
    waitCycles(3);
    checkOutput("rst_data_out",   lnk64.data_out, 64'd0);
    checkOutput("rst_valid",      64'(lnk64.data_valid), 64'd0);
    checkOutput("rst_err",        64'(lnk64.frame_err), 64'd0);
    checkOutput("rst_busy",       64'(lnk64.busy), 64'd0);
    checkOutput("rst_bit_cnt",    64'(lnk64.bit_cnt), 64'd0);
    checkOutput("rst_frame_cnt",  64'(lnk64.frame_cnt), 64'd0);
    checkOutput("rst_data_out16", 64'(lnk16.data_out), 64'd0);
    rst = 1'b0;
    waitCycles(4);

    // Good 64-bit frame with exact strobe latency.
    v0 = vld64; e0 = err64;
    startFrame();
    checkOutput("a_busy", 64'(lnk64.busy), 64'd1);
    applyStimulus({64'd0, FRAME_A}, 64, 1'b0);
    waitCycles(4);
    checkOutput("a_bit_cnt", 64'(lnk64.bit_cnt), 64'd64);
    drv_pen = 1'b1;
    waitCycles(3);
    checkOutput("a_valid_early", 64'(lnk64.data_valid), 64'd0);
    waitCycles(1);
    checkOutput("a_valid_at_4", 64'(lnk64.data_valid), 64'd1);
    checkOutput("a_data_out", lnk64.data_out, FRAME_A);
    waitCycles(1);
    checkOutput("a_valid_after", 64'(lnk64.data_valid), 64'd0);
    waitCycles(4);
    checkOutput("a_valid_count", 64'(vld64 - v0), 64'd1);
    checkOutput("a_err_count", 64'(err64 - e0), 64'd0);
    checkOutput("a_busy_done", 64'(lnk64.busy), 64'd0);
    checkOutput("a_frame_cnt", 64'(lnk64.frame_cnt), expCnt(1));

    // Short then long frames are rejected, data_out holds.
    v0 = vld64; e0 = err64;
    startFrame();
    applyStimulus(128'h7FFF_FFFF_0000_1234, 63, 1'b0);
    waitCycles(4);
    checkOutput("short_bit_cnt", 64'(lnk64.bit_cnt), 64'd63);
    drv_pen = 1'b1;
    waitCycles(HALF);
    checkOutput("short_err_count", 64'(err64 - e0), 64'd1);
    startFrame();
    applyStimulus(128'h1_5555_AAAA_5555_AAAA, 65, 1'b0);
    waitCycles(4);
    checkOutput("long_bit_cnt", 64'(lnk64.bit_cnt), 64'd65);
    drv_pen = 1'b1;
    waitCycles(HALF);
    checkOutput("long_err_count", 64'(err64 - e0), 64'd2);
    checkOutput("bad_valid_count", 64'(vld64 - v0), 64'd0);
    checkOutput("bad_data_hold", lnk64.data_out, FRAME_A);

    // Link clear mid-frame, then a full frame.
    v0 = vld64; e0 = err64;
    startFrame();
    applyStimulus(128'h3FFF_FFFF, 30, 1'b0);
    waitCycles(2);
    drv_clrn = 1'b0;
    waitCycles(4);
    checkOutput("clrn_busy", 64'(lnk64.busy), 64'd0);
    checkOutput("clrn_bit_cnt", 64'(lnk64.bit_cnt), 64'd0);
    drv_clrn = 1'b1;
    waitCycles(4);
    drv_pen = 1'b1;
    waitCycles(HALF);
    checkOutput("clrn_no_valid", 64'(vld64 - v0), 64'd0);
    checkOutput("clrn_no_err", 64'(err64 - e0), 64'd0);
    sendFrame({64'd0, FRAME_B}, 64);
    checkOutput("b_valid_count", 64'(vld64 - v0), 64'd1);
    checkOutput("b_data_out", lnk64.data_out, FRAME_B);

    // Reset mid-frame aborts everything; link returns to idle with it.
    startFrame();
    applyStimulus({64'd0, FRAME_C}, 20, 1'b0);
    rst = 1'b1;
    drv_pen = 1'b1;
    drv_dat = 1'b0;
    drv_clk = 1'b0;
    waitCycles(1);
    checkOutput("mid_rst_data_out", lnk64.data_out, 64'd0);
    checkOutput("mid_rst_busy", 64'(lnk64.busy), 64'd0);
    checkOutput("mid_rst_bit_cnt", 64'(lnk64.bit_cnt), 64'd0);
    checkOutput("mid_rst_frame_cnt", 64'(lnk64.frame_cnt), 64'd0);
    rst = 1'b0;
    v0 = vld64; e0 = err64;
    waitCycles(6);
    checkOutput("mid_rst_no_strobe", 64'((vld64 - v0) + (err64 - e0)), 64'd0);
    sendFrame({64'd0, FRAME_A}, 64);
    checkOutput("post_rst_data_out", lnk64.data_out, FRAME_A);
    checkOutput("post_rst_valid", 64'(vld64 - v0), 64'd1);

    // Two more good frames and one bad one for the frame counter.
    sendFrame({64'd0, 64'd1}, 64);
    checkOutput("one_data_out", lnk64.data_out, 64'd1);
    sendFrame({64'd0, FRAME_C}, 64);
    sendFrame(128'h2AA, 10);
    checkOutput("cnt_data_out", lnk64.data_out, FRAME_C);
    checkOutput("cnt_err_count", 64'(err64 - e0), 64'd1);
    checkOutput("cnt_frame_cnt", 64'(lnk64.frame_cnt), expCnt(3));

    // 16-bit receiver: last s_clk rise lands with the s_pen rise.
    sel16 = 1'b1;
    waitCycles(6);
    v0 = vld64; e0 = err64;
    startFrame();
    applyStimulus(128'hA5C3, 16, 1'b1);
    waitCycles(4);
    checkOutput("w16_valid_count", 64'(vld16), 64'd1);
    checkOutput("w16_err_count", 64'(err16), 64'd0);
    checkOutput("w16_data_out", 64'(lnk16.data_out), 64'hA5C3);
    checkOutput("w16_frame_cnt", 64'(lnk16.frame_cnt), expCnt(1));
    checkOutput("w16_rx64_quiet", 64'((vld64 - v0) + (err64 - e0)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_shift_rx.md
# serial_shift_rx

Receiving end of the board's serial shift-register display link (clock, data, latch-enable, clear). It oversamples the four link wires in the system clock domain, deserializes one frame MSB-first, checks the bit count, and presents the frame as a parallel word with a one-cycle valid strobe. Typical uses are a loop-back checker for the LED and seven-segment serializers, and a parallel-capture front end on a second board driven by the same link.

## Interface
Parameters:
- WIDTH, 64, frame length in bits. Use 64 for the seven-segment link and 16 for the LED link.
- SYNC_STAGES, 2, synchronizer flops per input. Legal range is 2..4.

Ports:
- clk  in  1  system clock. This is the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- s_clk  in  1  link shift clock. Asynchronous to clk.
- s_dat  in  1  link serial data.
- s_pen  in  1  link latch enable. Low while shifting; its rising edge commits the frame.
- s_clrn  in  1  link clear, active low.
- data_out  out  WIDTH  last good frame.
- data_valid  out  1  one-cycle strobe when data_out updates.
- frame_err  out  1  one-cycle strobe when a frame is rejected.
- busy  out  1  high while in SHIFT.
- bit_cnt  out  $clog2(WIDTH+1)+1  bits received in the current frame. Saturates at WIDTH+1.
- frame_cnt  out  16  count of good frames. See Configuration.

## Operation
- Each input passes through SYNC_STAGES flops. One further register provides edge detection. All logic acts on the synchronized signals only.
- State IDLE:
  - A falling edge of s_pen moves to SHIFT.
  - On entry, the shift register and bit_cnt clear.
  - s_clk edges in IDLE are ignored.
- State SHIFT:
  - On each s_clk rising edge, shift_reg <= {shift_reg[WIDTH-2:0], s_dat_sync}, and bit_cnt increments, saturating at WIDTH+1.
  - The first bit received ends in data_out[WIDTH-1].
  - A rising edge of s_pen moves to COMMIT.
- State COMMIT (one cycle):
  - If bit_cnt == WIDTH: data_out <= shift_reg and data_valid = 1.
  - Otherwise frame_err = 1 and data_out holds its previous value.
  - The block then returns to IDLE.
- Simultaneous s_clk rise and s_pen rise in the same synchronized cycle: the bit is shifted and counted first, and is part of the committed frame.
- Short frame (bit_cnt < WIDTH) and long frame (bit_cnt > WIDTH) both give frame_err. A long frame's shift register holds its last WIDTH bits, but that content is discarded.
- s_clrn low (synchronized), in any state:
  - The shift register and bit_cnt clear and the FSM goes to IDLE.
  - No strobe is issued and data_out holds.
  - s_clrn has priority over every other event in the same cycle.
- Reset values: state = IDLE; data_out = 0; data_valid = 0; frame_err = 0; busy = 0; bit_cnt = 0; frame_cnt = 0.
- The synchronizer flops reset to idle-link levels: s_clk = 0, s_dat = 0, s_pen = 1, s_clrn = 1.
- Reset asserted mid-frame aborts the frame with no strobe.

## Timing
- Link-pin edge to the internal synchronized edge: SYNC_STAGES+1 clk cycles.
- s_pen rising at the pin to data_valid or frame_err: SYNC_STAGES+2 cycles. That is 4 cycles at the default setting.
- data_out changes in the same cycle data_valid is high, and is stable until the next valid strobe.
- The link must meet these minimums or edges are missed:
  - s_clk high and low time ≥ SYNC_STAGES+1 clk cycles.
  - s_dat setup to the s_clk rise ≥ 1 clk cycle, and hold ≥ SYNC_STAGES+1 clk cycles.
  - s_pen low-to-high spacing ≥ SYNC_STAGES+2 clk cycles.
- Back-to-back frames are accepted. A falling edge of s_pen one cycle after COMMIT is recognized.

## Configuration
- SERIAL_RX_FRAME_CNT_EN defined: frame_cnt increments by 1 on every data_valid and wraps from 16'hFFFF to 0. It is not reset by s_clrn, only by rst.
- SERIAL_RX_FRAME_CNT_EN undefined: frame_cnt is tied to 0 and no counter logic is generated.

## Test plan
- Send WIDTH=64 frame 64'h0123_4567_89AB_CDEF, MSB-first, with 8-cycle s_clk half-periods -> data_out = 64'h0123_4567_89AB_CDEF, a single data_valid pulse 4 cycles after s_pen rises, frame_err = 0.
- Send a 63-bit frame, then a 65-bit frame -> two frame_err pulses, no data_valid, data_out unchanged, bit_cnt = 63 and then 65 before each commit.
- Pulse s_clrn low after 30 bits, then send a full 64'hFFFF_0000_FFFF_0000 frame -> no strobe from the aborted frame; the second frame produces a single data_valid with the correct data.
- Assert rst for 1 cycle mid-frame -> every output returns to its reset value and busy = 0. A subsequent full frame is received correctly.
- Drive the last s_clk rise in the same cycle as the s_pen rise, WIDTH=16, frame 16'hA5C3 -> data_valid with data_out = 16'hA5C3.
- With SERIAL_RX_FRAME_CNT_EN defined, send 3 good frames and 1 bad frame -> frame_cnt = 3. With the macro undefined, frame_cnt = 0 throughout.
